// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : UART transmitter draining a show-ahead byte FIFO. Pops one
//                byte per frame and serialises it as start / 8 data (LSB
//                first) / optional parity / 1-2 stop bits on tx.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] bytes_sent
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // Value of the stop-bit counter during the final stop bit.
  localparam logic            STOP_LAST = (STOP_BITS == 2);
  // Seed folded into the data XOR so odd parity needs no extra logic.
  localparam logic            PAR_SEED  = (PARITY_ODD != 0);
  localparam logic            HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [7:0]        shift;
  logic              parity_bit;
  logic [2:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;
  logic              stop_cnt;
  logic              baud_last;
  logic              load;
  logic              done_set;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE);

  // State register; reset forces IDLE so tx returns high without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, line level and FIFO pop decode.
  always_comb begin
    next_state = state;
    fifo_rd    = 1'b0;
    tx         = 1'b1;
    load       = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so nothing is popped while held in reset.
        fifo_rd = rst_n & enable & ~fifo_empty;
        load    = fifo_rd;
        if (fifo_rd) begin
          next_state = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_last) begin
          next_state = DATA;
        end
      end
      DATA: begin
        tx = shift[0];
        if (baud_last && (bit_cnt == 3'd7)) begin
          next_state = HAS_PAR ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx = parity_bit;
        if (baud_last) begin
          next_state = STOP;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (baud_last && (stop_cnt == STOP_LAST)) begin
          done_set   = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Baud counter: held at zero in IDLE, wraps at every bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if ((state == IDLE) || baud_last) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + BAUD_W'(1);
    end
  end

  // Byte capture at the pop edge and LSB-first shifting during DATA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= 8'h00;
      parity_bit <= 1'b0;
      bit_cnt    <= 3'd0;
    end else if (load) begin
      shift      <= fifo_data;
      parity_bit <= (^fifo_data) ^ PAR_SEED;
      bit_cnt    <= 3'd0;
    end else if ((state == DATA) && baud_last) begin
      shift      <= {1'b0, shift[7:1]};
      bit_cnt    <= bit_cnt + 3'd1;
    end
  end

  // Stop-bit counter, only meaningful when two stop bits are configured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stop_cnt <= 1'b0;
    end else if (load) begin
      stop_cnt <= 1'b0;
    end else if ((state == STOP) && baud_last) begin
      stop_cnt <= ~stop_cnt;
    end
  end

  // Completion pulse and frame counter, both updated on the final stop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      bytes_sent <= 16'h0000;
    end else begin
      frame_done <= done_set;
      if (done_set) begin
        bytes_sent <= bytes_sent + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the 16-entry byte FIFO and sends each byte as an asynchronous UART frame on `tx`. It sits on the FIFO's read side: it watches `fifo_empty`, samples the FIFO's show-ahead read data, and issues one-cycle read strobes. One strobe is issued per transmitted byte.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be ≥ 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:

- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: permits starting a new frame. Does not abort a frame in progress.
- `fifo_data` input 8: FIFO read data. Valid whenever `fifo_empty`=0 (show-ahead).
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rd` output 1: FIFO read strobe (pop). Combinational, high for exactly one cycle per byte.
- `tx` output 1: serial line. Idles high.
- `busy` output 1: high while a frame is in progress (any state other than IDLE).
- `frame_done` output 1: registered pulse, one cycle, after the last stop bit completes.
- `bytes_sent` output 16: count of completed frames.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx`=1.
  - `fifo_rd` = `enable` & ~`fifo_empty`.
  - On an edge where `fifo_rd`=1:
    - shift register ← `fifo_data`;
    - parity ← ^`fifo_data` ^ `PARITY_ODD`;
    - bit and baud counters ← 0;
    - go to START.
  - The FIFO pops on the same edge, so the byte is consumed exactly once.
- **START**: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `tx` = shift[0]; LSB first.
  - Every `CLKS_PER_BIT` cycles: shift right, increment the 3-bit bit counter.
  - After bit 7, go to PARITY if `PARITY_EN`=1, else to STOP.
- **PARITY**: `tx` = parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP**
  - `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - On the final cycle: `frame_done` ← 1 (registered, visible the next cycle), `bytes_sent` ← `bytes_sent`+1, go to IDLE.
- Baud counter: width $clog2(`CLKS_PER_BIT`). Counts 0..`CLKS_PER_BIT`−1 and rolls to 0 at each bit boundary.
- `fifo_rd` is never asserted outside IDLE. The FIFO cannot underflow when `fifo_empty` is obeyed.
- `enable` deasserted mid-frame: the current frame completes normally; no new pop occurs.
- `fifo_empty` or `fifo_data` changing mid-frame has no effect, because the data was latched at the pop.
- `bytes_sent` wraps from 0xFFFF to 0x0000.
- Asynchronous reset, including mid-frame:
  - immediately: state=IDLE, `tx`=1, `frame_done`=0, `bytes_sent`=0;
  - shift register, parity and counters = 0;
  - `fifo_rd`=0 while `rst_n`=0;
  - a partially sent byte is lost and is not re-read.

## Timing

- Reset values: `tx`=1, `busy`=0, `frame_done`=0, `bytes_sent`=0, `fifo_rd`=0.
- Pop edge to start bit: `tx` falls on the cycle after the pop edge. Latency is 1 clock.
- Frame length: (1 + 8 + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, from start-bit cycle to last stop cycle inclusive.
- Back-to-back frames:
  - The FSM returns to IDLE for exactly one cycle.
  - `fifo_rd` fires in that cycle if data is available.
  - Effective stop time is therefore `STOP_BITS`×`CLKS_PER_BIT`+1 cycles.
  - Frame period is N+1 cycles, where N is the frame length above.
- `frame_done` coincides with the first IDLE cycle, the same cycle as the next `fifo_rd`.
- `bytes_sent` updates on the same edge that raises `frame_done`.
- `busy` is high from the first START cycle through the last STOP cycle.

## Test plan

- **Single byte, basic frame.**
  - Stimulus: `CLKS_PER_BIT`=4, no parity, 1 stop; FIFO holds 0x55; `enable`=1.
  - Response: exactly one `fifo_rd` pulse. `tx` shows 0 for 4 clocks, then data bits 1,0,1,0,1,0,1,0 for 4 clocks each, then 1. `frame_done` pulses once. `bytes_sent`=1.
- **Even parity.**
  - Stimulus: `PARITY_EN`=1, `PARITY_ODD`=0, byte 0x07.
  - Response: parity bit is 1.
  - Repeat with `PARITY_ODD`=1: parity bit is 0. Frame is 44 cycles at `CLKS_PER_BIT`=4.
- **Back-to-back.**
  - Stimulus: FIFO preloaded with 0xA1, 0xB2, 0xC3; `enable`=1.
  - Response: 3 `fifo_rd` pulses, 41 cycles apart. Decoded bytes match in order. `fifo_empty` ends high. `bytes_sent`=3. No 4th pop.
- **Empty FIFO.**
  - Stimulus: `enable`=1 with `fifo_empty`=1 for 100 cycles.
  - Response: `fifo_rd`=0, `tx`=1, `busy`=0 throughout.
- **Enable drop mid-frame.**
  - Stimulus: deassert `enable` during DATA with 2 bytes queued.
  - Response: the current frame finishes; no further pop until `enable` returns; the second byte then sends intact.
- **Reset mid-frame.**
  - Stimulus: assert `rst_n`=0 during bit 3.
  - Response: `tx`=1 and `busy`=0 with no clock edge required; `bytes_sent`=0. After release, the next queued byte sends with a full, correct frame.
